pattern_applier: RTL and testbench
==================================

# pattern_applier

Hardware test-vector applier and response checker, the consuming end of the pattern/response files produced by the fault-simulation flow. Fetches stored vectors (stimulus, expected response, compare mask) from an external synchronous-read memory, drives each stimulus onto a circuit under test (CUT), waits a programmable settle time, then compares the masked CUT response. Reports the pass/fail verdict, a saturating mismatch count, and the index of the first failing vector.

## Interface
- IN_W, 2: CUT input width (stimulus bits per vector).
- OUT_W, 1: CUT output width (expected and mask bits per vector).
- AW, 2: vector address width; up to 2^AW vectors.
- SETTLE, 1: cycles between stimulus update and response compare; legal range 1..15.
- CNT_W, 4: mismatch counter width.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; honoured only in IDLE.
- num_vec  input  AW+1  number of vectors to apply, sampled with start; 0..2^AW.
- vec_addr  output  AW  vector memory read address.
- vec_data  input  IN_W+2*OUT_W  {stimulus, expected, mask}; valid the cycle after vec_addr is presented.
- cut_in  output  IN_W  registered stimulus to the CUT.
- cut_out  input  OUT_W  CUT response.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at run end.
- pass  output  1  1 when the last run had zero mismatches; valid from done until the next accepted start.
- fail_cnt  output  CNT_W  mismatching vectors in the current/last run, saturating.
- first_fail_idx  output  AW  index of the first mismatching vector.
- first_fail_vld  output  1  first_fail_idx is valid.

## Operation
- FSM states: IDLE, FETCH, APPLY, SETTLE, COMPARE, DONE.
- IDLE: start=1 and num_vec>0 -> latch num_vec, clear idx, fail_cnt, first_fail_vld; go to FETCH. start=1 and num_vec=0 -> go to DONE with counters cleared (pass=1).
- FETCH: vec_addr=idx; -> APPLY.
- APPLY: vec_data is valid; register the stimulus into cut_in and the expected/mask bits into internal registers; load settle counter = SETTLE; -> SETTLE.
- SETTLE: decrement the counter; at 1 -> COMPARE.
- COMPARE: mismatch = |((cut_out ^ expected) & mask). If mismatch: fail_cnt += 1 unless it is already all-ones; if !first_fail_vld, set first_fail_idx=idx and first_fail_vld=1. If idx == num_vec-1 -> DONE, else idx+1 -> FETCH.
- DONE: done=1 for this cycle; pass = (fail_cnt==0) && !overflow; -> IDLE.
- A mask of all zeros makes the vector always pass.
- The saturated fail count is held at 2^CNT_W-1. pass remains 0.
- start asserted in any state other than IDLE is ignored.
- cut_in holds the last stimulus after the run ends. Results hold until the next accepted start.

## Timing
- Reset values: state=IDLE, vec_addr=0, cut_in=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_idx=0, first_fail_vld=0.
- Each vector takes 3+SETTLE cycles (FETCH, APPLY, SETTLE×SETTLE, COMPARE).
- With start sampled at edge 0: busy rises after edge 0; cut_in for vector 0 changes after edge 2. cut_out is sampled at the end of the COMPARE cycle.
- done pulses (3+SETTLE)·num_vec+1 cycles after the start edge; busy falls with done. For num_vec=0, done comes 1 cycle after start.
- rst has priority over everything: it aborts a run mid-operation and returns all outputs to their reset values on the next edge. No done pulse is generated.
- A back-to-back start in the cycle after done is accepted.

## Test plan
- XNOR CUT, SETTLE=1, 4 vectors {00→1, 01→0, 10→0, 11→1}, mask=1 -> done at cycle 17, pass=1, fail_cnt=0, first_fail_vld=0, cut_in sequence 00,01,10,11.
- CUT output stuck-at-0, same vectors -> pass=0, fail_cnt=2, first_fail_idx=0, first_fail_vld=1.
- Stuck-at-0 CUT with the mask cleared on vectors 0 and 3 -> pass=1, fail_cnt=0.
- num_vec=0 -> done one cycle after start, pass=1, no vec_addr change. A start pulsed while busy does not restart the run, and the cycle count is unchanged.
- CNT_W=2, 4 failing vectors, always-wrong CUT -> fail_cnt saturates at 3, pass=0.
- rst asserted during SETTLE of vector 2 -> next cycle: IDLE, busy=0, fail_cnt=0, cut_in=0, no done. A fresh start then completes normally.

Source files
------------

// File: rtl/pattern_applier.sv
// Test-vector applier: fetches {stimulus, expected, mask} vectors, drives the CUT,
// waits a settle time, and compares the masked response, tracking pass/fail results.
module pattern_applier #(
    parameter int unsigned IN_W   = 2,
    parameter int unsigned OUT_W  = 1,
    parameter int unsigned AW     = 2,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AW:0]              num_vec,
    output logic [AW-1:0]            vec_addr,
    input  logic [IN_W+2*OUT_W-1:0]  vec_data,
    output logic [IN_W-1:0]          cut_in,
    input  logic [OUT_W-1:0]         cut_out,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [AW-1:0]            first_fail_idx,
    output logic                     first_fail_vld
);

    localparam int unsigned DW = IN_W + 2 * OUT_W;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StApply,
        StSettle,
        StCompare,
        StDone
    } state_e;

    state_e             state_q;
    logic [AW:0]        num_q;
    logic [AW-1:0]      idx_q;
    logic [OUT_W-1:0]   exp_q;
    logic [OUT_W-1:0]   mask_q;
    logic [3:0]         settle_q;

    logic mismatch;
    logic last_vec;

    assign mismatch = |((cut_out ^ exp_q) & mask_q);
    assign last_vec = ({1'b0, idx_q} == (num_q - (AW + 1)'(1)));
    // The vector index register doubles as the memory address.
    assign vec_addr = idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            num_q          <= '0;
            idx_q          <= '0;
            exp_q          <= '0;
            mask_q         <= '0;
            settle_q       <= '0;
            cut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        fail_cnt       <= '0;
                        first_fail_idx <= '0;
                        first_fail_vld <= 1'b0;
                        if (num_vec != '0) begin
                            num_q   <= num_vec;
                            idx_q   <= '0;
                            busy    <= 1'b1;
                            pass    <= 1'b0;
                            state_q <= StFetch;
                        end else begin
                            pass    <= 1'b1;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StFetch: begin
                    state_q <= StApply;
                end
                StApply: begin
                    cut_in   <= vec_data[DW-1 -: IN_W];
                    exp_q    <= vec_data[2*OUT_W-1 -: OUT_W];
                    mask_q   <= vec_data[OUT_W-1:0];
                    settle_q <= 4'(SETTLE);
                    state_q  <= StSettle;
                end
                StSettle: begin
                    settle_q <= settle_q - 4'd1;
                    if (settle_q <= 4'd1) begin
                        state_q <= StCompare;
                    end
                end
                StCompare: begin
                    if (mismatch) begin
                        if (!(&fail_cnt)) begin
                            fail_cnt <= fail_cnt + CNT_W'(1);
                        end
                        if (!first_fail_vld) begin
                            first_fail_idx <= idx_q;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (last_vec) begin
                        // Verdict includes this final compare, so it is valid alongside done.
                        pass    <= (fail_cnt == '0) && !mismatch;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + AW'(1);
                        state_q <= StFetch;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_applier.sv
// Self-checking bench for pattern_applier: synchronous vector memory, table-driven CUT,
// and a reference model that scores each run from the stored vectors.
module tb_pattern_applier;

    localparam int unsigned IN_W   = 2;
    localparam int unsigned OUT_W  = 1;
    localparam int unsigned AW     = 2;
    localparam int unsigned SETTLE = 1;
    localparam int unsigned CNT_W  = 2;
    localparam int          PER    = 3 + SETTLE;
    localparam int          SATMAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst;
    logic               start;
    logic [AW:0]        num_vec;
    logic [AW-1:0]      vec_addr;
    logic [IN_W+2*OUT_W-1:0] vec_data;
    logic [IN_W-1:0]    cut_in;
    logic [OUT_W-1:0]   cut_out;
    logic               busy;
    logic               done;
    logic               pass;
    logic [CNT_W-1:0]   fail_cnt;
    logic [AW-1:0]      first_fail_idx;
    logic               first_fail_vld;

    logic [1:0] stim  [4];
    logic       expv  [4];
    logic       maskv [4];
    logic       tbl   [4];

    int n_cmp;
    int n_bad;

    pattern_applier #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .AW     (AW),
        .SETTLE (SETTLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_vec        (num_vec),
        .vec_addr       (vec_addr),
        .vec_data       (vec_data),
        .cut_in         (cut_in),
        .cut_out        (cut_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_vld (first_fail_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) vec_data <= {stim[vec_addr], expv[vec_addr], maskv[vec_addr]};
    assign cut_out = tbl[cut_in];

    // Vectors model an XNOR gate; cut_mode picks the CUT: 0 xnor, 1 stuck-at-0, 2 inverted.
    task automatic load_xnor(input int cut_mode);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v = 2'(i);
            stim[i]  = v;
            expv[i]  = ~(v[1] ^ v[0]);
            maskv[i] = 1'b1;
            case (cut_mode)
                0:       tbl[i] = ~(v[1] ^ v[0]);
                1:       tbl[i] = 1'b0;
                default: tbl[i] = v[1] ^ v[0];
            endcase
        end
    endtask

    task automatic model(input int n, output int ecnt, output int efirst);
        int count;
        count  = 0;
        efirst = -1;
        for (int j = 0; j < n; j++) begin
            if (((tbl[stim[j]] ^ expv[j]) & maskv[j]) != 1'b0) begin
                count++;
                if (efirst < 0) efirst = j;
            end
        end
        ecnt = (count > SATMAX) ? SATMAX : count;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
    task automatic run_and_check(input string name, input int n, input int glitch_at);
        int  done_k;
        int  ecnt;
        int  efirst;
        bit  epass;
        bit  busy_ok;
        int  limit;
        model(n, ecnt, efirst);
        epass   = (ecnt == 0);
        start   = 1'b1;
        num_vec = 3'(n);
        @(posedge clk);
        #1;
        start   = 1'b0;
        num_vec = 3'($urandom);
        done_k  = 0;
        busy_ok = 1'b1;
        limit   = PER * n + 20;
        for (int k = 1; k <= limit && done_k == 0; k++) begin
            @(negedge clk);
            start = (k == glitch_at);
            if (done) begin
                done_k = k;
                if (busy !== 1'b0) busy_ok = 1'b0;
            end else if (busy !== (n > 0)) begin
                busy_ok = 1'b0;
            end
            if (n > 0 && k >= 1 && ((k - 1) % PER) == 0 && (k - 1) / PER < n) begin
                n_cmp++;
                if (vec_addr !== 2'((k - 1) / PER)) begin
                    n_bad++;
                    $display("FAIL %s vec_addr@%0d: got %0d want %0d", name, k, vec_addr,
                             (k - 1) / PER);
                end
            end
            if (n > 0 && k >= 3 && ((k - 3) % PER) == 0 && (k - 3) / PER < n) begin
                n_cmp++;
                if (cut_in !== stim[(k - 3) / PER]) begin
                    n_bad++;
                    $display("FAIL %s cut_in@%0d: got %b want %b", name, k, cut_in,
                             stim[(k - 3) / PER]);
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (done_k !== PER * n + 1) begin
            n_bad++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_k, PER * n + 1);
        end
        n_cmp++;
        if (!busy_ok) begin
            n_bad++;
            $display("FAIL %s busy_window: got bad busy profile want high until done", name);
        end
        n_cmp++;
        if (pass !== epass) begin
            n_bad++;
            $display("FAIL %s pass: got %b want %b", name, pass, epass);
        end
        n_cmp++;
        if (fail_cnt !== 2'(ecnt)) begin
            n_bad++;
            $display("FAIL %s fail_cnt: got %0d want %0d", name, fail_cnt, ecnt);
        end
        n_cmp++;
        if (first_fail_vld !== (efirst >= 0)) begin
            n_bad++;
            $display("FAIL %s first_fail_vld: got %b want %b", name, first_fail_vld,
                     efirst >= 0);
        end
        if (efirst >= 0) begin
            n_cmp++;
            if (first_fail_idx !== 2'(efirst)) begin
                n_bad++;
                $display("FAIL %s first_fail_idx: got %0d want %0d", name, first_fail_idx,
                         efirst);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done, pass, fail_cnt} !== {1'b0, epass, 2'(ecnt)}) begin
            n_bad++;
            $display("FAIL %s hold: got done=%b pass=%b cnt=%0d want done=0 pass=%b cnt=%0d",
                     name, done, pass, fail_cnt, epass, ecnt);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        num_vec = '0;
        load_xnor(0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({vec_addr, cut_in, busy, done, pass, fail_cnt, first_fail_idx, first_fail_vld}
            !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 000",
                     {vec_addr, cut_in, busy, done, pass, fail_cnt, first_fail_idx,
                      first_fail_vld});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_vec();
        run_and_check("zero_vec", 0, 0);
        n_cmp++;
        if (vec_addr !== 2'd0) begin
            n_bad++;
            $display("FAIL zero_vec vec_addr: got %0d want 0", vec_addr);
        end
    endtask

    task automatic test_xnor();
        load_xnor(0);
        run_and_check("xnor", 4, 0);
    endtask

    task automatic test_stuck0();
        load_xnor(1);
        run_and_check("stuck0", 4, 0);
    endtask

    task automatic test_masked();
        load_xnor(1);
        maskv[0] = 1'b0;
        maskv[3] = 1'b0;
        run_and_check("masked", 4, 0);
    endtask

    task automatic test_start_ignored();
        load_xnor(1);
        run_and_check("start_busy", 4, 6);
    endtask

    task automatic test_saturate();
        load_xnor(2);
        run_and_check("saturate", 4, 0);
    endtask

    task automatic test_reset_midrun();
        bit saw_done;
        load_xnor(1);
        start   = 1'b1;
        num_vec = 3'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Cycle 11 after the start edge is the settle cycle of vector 2.
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({vec_addr, cut_in, busy, done, pass, fail_cnt, first_fail_idx, first_fail_vld}
            !== 12'h000) begin
            n_bad++;
            $display("FAIL midrun_reset: got %h want 000",
                     {vec_addr, cut_in, busy, done, pass, fail_cnt, first_fail_idx,
                      first_fail_vld});
        end
        rst      = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            n_bad++;
            $display("FAIL midrun_quiet: got done/busy activity want none");
        end
        load_xnor(0);
        run_and_check("after_reset", 4, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            int n;
            int g;
            for (int i = 0; i < 4; i++) begin
                stim[i]  = 2'($urandom);
                expv[i]  = 1'($urandom);
                maskv[i] = ($urandom_range(0, 3) != 0);
                tbl[i]   = 1'($urandom);
            end
            n = $urandom_range(0, 4);
            g = (n > 0) ? $urandom_range(1, PER * n) : 0;
            run_and_check($sformatf("rand%0d", r), n, g);
        end
    endtask

    task automatic test_back_to_back();
        load_xnor(1);
        run_and_check("b2b_a", 2, 0);
        load_xnor(0);
        run_and_check("b2b_b", 3, 0);
        load_xnor(2);
        run_and_check("b2b_c", 1, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_zero_vec();
        test_xnor();
        test_stuck0();
        test_masked();
        test_start_ignored();
        test_saturate();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
